// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the decode-stage interlock: FSM encoding, shadow-slot layouts
// and forwarding-mode selectors.
package id_hazard_ctrl_pkg;

  localparam int REG_W = 3;

  localparam bit FWD_NONE = 1'b0;
  localparam bit FWD_EX   = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wr;
    logic             ld;
  } ex_slot_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wr;
  } mem_slot_t;

  // True when a valid in-flight writer targets a source the ID instruction reads.
  function automatic logic src_match(input logic             v,
                                     input logic [REG_W-1:0] wr,
                                     input logic             rs_used,
                                     input logic [REG_W-1:0] rs,
                                     input logic             rt_used,
                                     input logic [REG_W-1:0] rt);
    return (rs_used & v & (wr == rs)) | (rt_used & v & (wr == rt));
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_inflight_tracker.sv
// Two-slot shadow of the EX and MEM stages recording which register each
// in-flight instruction will write, with per-slot source-match outputs.
module inflight_tracker
  import id_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_i,
  input  logic             reg_write_i,
  input  logic [REG_W-1:0] write_reg_i,
  input  logic             mem_read_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             rs_used_i,
  input  logic             rt_used_i,
  output logic             ex_match_o,
  output logic             mem_match_o,
  output logic             ex_load_o,
  output logic             busy_o
);

  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q, mem_d;

  always_comb begin
    ex_d = '0;
    if (issue_i) begin
      ex_d.v  = reg_write_i;
      ex_d.wr = write_reg_i;
      ex_d.ld = mem_read_i;
    end
    mem_d.v  = ex_q.v;
    mem_d.wr = ex_q.wr;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  assign ex_match_o  = src_match(ex_q.v, ex_q.wr, rs_used_i, rs_i, rt_used_i, rt_i);
  assign mem_match_o = src_match(mem_q.v, mem_q.wr, rs_used_i, rs_i, rt_used_i, rt_i);
  assign ex_load_o   = ex_q.ld;
  assign busy_o      = ex_q.v | mem_q.v;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock: stalls on RAW hazards, flushes on EX redirects,
// bubbles ID/EX, and drains then freezes the pipe on HALT.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter bit FORWARD = FWD_NONE,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_regWrite,
  input  logic [REG_W-1:0] id_writereg,
  input  logic             id_memRead,
  input  logic             id_halt,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             drain_seen_q, drain_seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_match, mem_match, ex_load, busy;
  logic             hazard, issue;

  inflight_tracker u_tracker (
    .clk         (clk),
    .rst_n       (rst),
    .issue_i     (issue),
    .reg_write_i (id_regWrite),
    .write_reg_i (id_writereg),
    .mem_read_i  (id_memRead),
    .rs_i        (id_rs),
    .rt_i        (id_rt),
    .rs_used_i   (id_rs_used),
    .rt_used_i   (id_rt_used),
    .ex_match_o  (ex_match),
    .mem_match_o (mem_match),
    .ex_load_o   (ex_load),
    .busy_o      (busy)
  );

  // With EX->EX forwarding only a load in EX cannot supply its result in time.
  assign hazard = (FORWARD == FWD_EX) ? (id_valid & ex_match & ex_load)
                                      : (id_valid & (ex_match | mem_match));
  assign issue  = (state_q == ST_RUN) & id_valid & ~hazard & ~ex_redirect;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    drain_seen_d = drain_seen_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_RUN: begin
        drain_seen_d = 1'b0;
        if (ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazard) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        end else if (!id_valid) begin
          idex_bubble = 1'b1;
        end
        if (issue && id_halt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_bubble  = 1'b1;
        drain_seen_d = 1'b1;
        // The HALT itself occupies EX for the first drain cycle, hence the two-cycle floor.
        if (drain_seen_q && !busy) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      drain_seen_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_seen_q <= drain_seen_d;
      cnt_q        <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: a no-forwarding instance with a narrow
// counter and a forwarding instance, checked through an expectation queue.
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_regWrite, id_memRead, id_halt, ex_redirect;
  logic [2:0] id_rs, id_rt, id_writereg;

  logic       pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, halted0;
  logic [2:0] cnt0;
  logic       pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, halted1;
  logic [15:0] cnt1;

  typedef struct {
    logic        sel;
    logic [20:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   c0       = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.FORWARD(1'b0), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regWrite(id_regWrite),
    .id_writereg(id_writereg), .id_memRead(id_memRead), .id_halt(id_halt),
    .ex_redirect(ex_redirect), .pc_stall(pc_stall0), .ifid_stall(ifid_stall0),
    .ifid_flush(ifid_flush0), .idex_bubble(idex_bubble0), .halted(halted0),
    .stall_count(cnt0)
  );

  id_hazard_ctrl #(.FORWARD(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regWrite(id_regWrite),
    .id_writereg(id_writereg), .id_memRead(id_memRead), .id_halt(id_halt),
    .ex_redirect(ex_redirect), .pc_stall(pc_stall1), .ifid_stall(ifid_stall1),
    .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .halted(halted1),
    .stall_count(cnt1)
  );

  function automatic int sat7(input int c);
    return (c > 7) ? 7 : c;
  endfunction

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic rw,
                       input logic [2:0] wr, input logic mr, input logic hl,
                       input logic rd);
    id_valid = v;  id_rs = rs;  id_rs_used = rsu;  id_rt = rt;  id_rt_used = rtu;
    id_regWrite = rw;  id_writereg = wr;  id_memRead = mr;  id_halt = hl;  ex_redirect = rd;
  endtask

  // ctl = {pc_stall, ifid_stall, ifid_flush, idex_bubble, halted}
  task automatic push(input logic sel, input logic [4:0] ctl, input int cnt, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = {ctl, 16'(cnt)};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [20:0] obs;
    e = sb.pop_front();
    obs = e.sel ? {pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, halted1, cnt1}
                : {pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, halted0, 13'd0, cnt0};
    n_checks++;
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s: observed ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                e.tag, obs[20:16], obs[15:0], e.val[20:16], e.val[15:0]);
  endtask

  task automatic cycle(input logic sel, input logic [4:0] ctl, input int cnt, input string tag);
    push(sel, ctl, cnt, tag);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    push(0, 5'b00000, 0, "reset_u0");  check_pop();
    push(1, 5'b00000, 0, "reset_u1");  check_pop();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // No forwarding: ADD r3 then a reader of r3 stalls while ADD sits in EX and MEM.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cycle(0, 5'b00010, 0, "idle_bubble");
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);  cycle(0, 5'b00000, 0, "add_r3_issue");
    drive(1, 3, 1, 0, 0, 1, 4, 0, 0, 0);  cycle(0, 5'b11010, 0, "raw_ex_stall");
    cycle(0, 5'b11010, 1, "raw_mem_stall");
    cycle(0, 5'b00000, 2, "raw_issue_cnt2");
    c0 = 2;
    drive(1, 4, 0, 4, 0, 0, 0, 0, 0, 0);  cycle(0, 5'b00000, c0, "unused_src_no_stall");
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);  cycle(0, 5'b00000, c0, "rt_nomatch");

    // Repeated writer/reader pairs drive the 3-bit counter into saturation.
    for (int p = 0; p < 4; p++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);  cycle(0, 5'b00000, c0, "sat_writer");
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);  cycle(0, 5'b11010, c0, "sat_stall_a");
      c0 = sat7(c0 + 1);
      cycle(0, 5'b11010, c0, "sat_stall_b");
      c0 = sat7(c0 + 1);
      cycle(0, 5'b00000, c0, "sat_issue");
    end

    // HALT behind a writer: two drain cycles, then frozen until reset.
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);  cycle(0, 5'b00000, c0, "pre_halt_writer");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  cycle(0, 5'b00000, c0, "halt_issue");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 5'b11010, c0, "drain_1");
    cycle(0, 5'b11010, c0, "drain_2");
    for (int i = 0; i < 12; i++) cycle(0, 5'b11011, c0, "halted_hold");
    #2 rst = 1'b0;
    #1;
    push(0, 5'b00000, 0, "async_reset_u0");  check_pop();
    push(1, 5'b00000, 0, "async_reset_u1");  check_pop();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // EX forwarding: only load-use stalls, and a redirect beats the hazard.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);  cycle(1, 5'b00000, 0, "ld_r5_issue");
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);  cycle(1, 5'b11010, 0, "load_use_stall");
    cycle(1, 5'b00000, 1, "load_use_issue");
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);  cycle(1, 5'b00000, 1, "add_r5_issue");
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0, 0);  cycle(1, 5'b00000, 1, "fwd_no_stall");
    drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);  cycle(1, 5'b00000, 1, "ld_r6_issue");
    drive(1, 6, 1, 0, 0, 1, 6, 1, 0, 1);  cycle(1, 5'b00110, 1, "redirect_over_hazard");
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);  cycle(1, 5'b00000, 1, "squashed_not_in_ex");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cycle(1, 5'b00010, 1, "fwd_idle_bubble");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Decode-stage interlock controller sitting between the IF/ID register and the ID/EX register.
- Tracks in-flight register writers in a shadow pipeline covering the EX and MEM slots.
- Stalls PC and IF/ID on RAW hazards and flushes on EX-resolved redirects.
- Injects bubbles into ID/EX by forcing its control inputs to zero, and drains then freezes the pipe on HALT.

Parameters:
- FORWARD, 0: 0 means no forwarding, so stall on any EX/MEM writer match. 1 means EX→EX forwarding exists, so stall only on load-use (EX slot is a load).
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs  in  3  source register 1
- id_rt  in  3  source register 2
- id_rs_used  in  1  rs is read by this instruction
- id_rt_used  in  1  rt is read by this instruction
- id_regWrite  in  1  instruction writes the register file
- id_writereg  in  3  destination register
- id_memRead  in  1  instruction is a load
- id_halt  in  1  instruction is HALT
- ex_redirect  in  1  branch/jump taken, resolved in EX this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  zero all control fields entering ID/EX
- halted  out  1  pipeline drained and frozen
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=0, async): state=RUN; EX/MEM slots invalid; stall_count=0; all control outputs 0.
- Slots: ex_slot{v,wr[2:0],ld}, mem_slot{v,wr[2:0]}. Every cycle: mem_slot<=ex_slot; ex_slot<=issue ? {id_regWrite,id_writereg,id_memRead} : 0. Slot valid only if regWrite was set.
- match(s) = (id_rs_used & s.v & s.wr==id_rs) | (id_rt_used & s.v & s.wr==id_rt).
- hazard:
  - FORWARD=0: id_valid & (match(ex_slot) | match(mem_slot)).
  - FORWARD=1: id_valid & match(ex_slot) & ex_slot.ld.
- WB stage is never a hazard; the register file bypasses write-before-read.
- issue = state==RUN & id_valid & !hazard & !ex_redirect.
- Priority in RUN: ex_redirect > hazard > issue.
  - ex_redirect: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0; the ID instruction is squashed (a HALT in ID is also squashed).
  - hazard: pc_stall=1, ifid_stall=1, idex_bubble=1, stall_count += 1, saturating at all-ones.
  - otherwise: all control outputs 0.
  - id_valid=0: idex_bubble=1, with no stall and no count.
- FSM:
  - RUN→DRAIN when issue & id_halt. The HALT itself is passed into ID/EX.
  - DRAIN: pc_stall=ifid_stall=idex_bubble=1; no issue; go to HALTED once ex_slot.v=0 and mem_slot.v=0 at the clock edge. The minimum is 2 cycles.
  - HALTED: pc_stall=ifid_stall=idex_bubble=halted=1. Only reset exits.
  - ex_redirect in DRAIN/HALTED is ignored; it cannot occur legally.
- Control outputs are combinational from state, slots and ID inputs (same-cycle). State, slots and counter are registered.
- Reset mid-stall or mid-drain: immediate return to RUN with slots cleared and counter 0.

Decomposition:
- Shared package:
  - state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10);
  - slot field widths (REG_W=3);
  - FORWARD mode constants.
- One sub-module, inflight_tracker: a two-slot shadow pipeline with match outputs, reused later for MEM/WB forwarding select.

Test Plan:
- FORWARD=0: ADD r3 issued, next ID reads rs=r3 → 2 stall cycles (pc_stall=ifid_stall=idex_bubble=1), issues on 3rd cycle; stall_count=2.
- FORWARD=1: LD r5 issued, next reads rt=r5 → exactly 1 stall cycle; a non-load writer to r5 → 0 stalls.
- Hazard and ex_redirect in the same cycle → ifid_flush=1, idex_bubble=1, pc_stall=0, stall_count unchanged, ex_slot invalid next cycle.
- HALT issued behind a writer → DRAIN for 2 cycles, then halted=1 held for 10+ cycles with all stalls asserted; rst low returns halted=0 asynchronously.
- Preload stall_count near all-ones and keep a hazard pending for 4 cycles → saturates at all-ones, no wrap.
- Source register unused (id_rs_used=0) but matching id_rs=EX.wr → no stall.
